// File: rtl/qam_tx_pkg.sv
// qam_tx_pkg: state encoding and shared constants for the QAM transmit sequencer.
package qam_tx_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam int UPS_MIN = 2;
endpackage

// File: rtl/qam_phase_counter.sv
// qam_phase_counter: registered modulo-N upsampler phase with a wrap strobe.
module qam_phase_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic         strb,
    input  logic [W-1:0] n,
    output logic [W-1:0] phase,
    output logic         wrap,
    output logic         zero
);
    logic [W-1:0] phase_q, phase_d;
    logic         wrap_q, zero_q;

    // Phase restarts at 0 whenever the sequencer is entering or sitting in IDLE.
    always_comb phase_d = !run ? '0 : (phase_q >= n - W'(1)) ? '0 : phase_q + W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
            wrap_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            wrap_q  <= strb && (phase_d == '0);
            zero_q  <= phase_d != '0;
        end
    end

    assign phase = phase_q;
    assign wrap  = wrap_q;
    assign zero  = zero_q;
endmodule

// File: rtl/qam_tx_sequencer.sv
// qam_tx_sequencer: IDLE/FILL/RUN/DRAIN control of the upsampler, FIR pair and CORDIC.
module qam_tx_sequencer import qam_tx_pkg::*; #(
    parameter int UPS_W   = 4,
    parameter int FILL_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [UPS_W-1:0] cfg_ups_factor,
    input  logic [FILL_W-1:0] cfg_fill_len,
    input  logic             fir_valid_i,
    input  logic             fir_valid_q,
    input  logic             cordic_valid,
    output logic             sym_req,
    output logic [UPS_W-1:0] up_phase,
    output logic             up_zero,
    output logic             fir_en,
    output logic             cordic_en,
    output logic             tx_valid,
    output logic             busy,
    output logic [1:0]       state_o,
    output logic             err_timeout,
    output logic             err_desync
);
    localparam logic [31:0] FILL_MAX = (32'd1 << FILL_W) - 32'd1;

    logic [1:0]        rst_sync_q;
    logic [1:0]        state_q, state_d;
    logic [UPS_W-1:0]  ups_q, ups_d;
    logic [FILL_W-1:0] len_q, len_d, fill_q, fill_d, drain_q, drain_d, fill_inc;
    logic [31:0]       lim;
    logic              tmo_d, desync_d, desync_q, tmo_q, en_q, tx_valid_q;

    // Start is only accepted once the released reset has passed two flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    always_comb begin
        state_d  = state_q;
        ups_d    = ups_q;
        len_d    = len_q;
        fill_d   = fill_q;
        drain_d  = drain_q;
        tmo_d    = 1'b0;
        desync_d = desync_q;
        fill_inc = (&fill_q) ? fill_q : fill_q + FILL_W'(1);
        lim      = (32'(len_q) + 32'(TIMEOUT) > FILL_MAX) ? FILL_MAX : 32'(len_q) + 32'(TIMEOUT);
        case (state_q)
            S_IDLE: if (start && rst_sync_q[1]) begin
                state_d  = S_FILL;
                ups_d    = (cfg_ups_factor < UPS_W'(UPS_MIN)) ? UPS_W'(UPS_MIN) : cfg_ups_factor;
                len_d    = cfg_fill_len;
                fill_d   = '0;
                drain_d  = '0;
                desync_d = 1'b0;
            end
            S_FILL: begin
                fill_d = fill_inc;
                if (stop) state_d = S_IDLE;
                else if (fir_valid_i && fir_valid_q && cordic_valid && fill_inc >= len_q) state_d = S_RUN;
                else if (32'(fill_inc) >= lim) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                end
            end
            S_RUN: if (stop) begin
                state_d = S_DRAIN;
                drain_d = len_q;
            end
            default: begin
                drain_d = (drain_q == '0) ? '0 : drain_q - FILL_W'(1);
                if (drain_q <= FILL_W'(1)) state_d = S_IDLE;
            end
        endcase
        if ((state_q == S_RUN || state_q == S_DRAIN) && fir_valid_i != fir_valid_q) desync_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ups_q      <= UPS_W'(UPS_MIN);
            len_q      <= '0;
            fill_q     <= '0;
            drain_q    <= '0;
            tmo_q      <= 1'b0;
            desync_q   <= 1'b0;
            en_q       <= 1'b0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ups_q      <= ups_d;
            len_q      <= len_d;
            fill_q     <= fill_d;
            drain_q    <= drain_d;
            tmo_q      <= tmo_d;
            desync_q   <= desync_d;
            en_q       <= state_d != S_IDLE;
            tx_valid_q <= state_d == S_RUN || state_d == S_DRAIN;
        end
    end

    qam_phase_counter #(.W(UPS_W)) u_phase (
        .clk   (clk),
        .reset (reset),
        .run   (state_q != S_IDLE && state_d != S_IDLE),
        .strb  (state_d == S_FILL || state_d == S_RUN),
        .n     (ups_q),
        .phase (up_phase),
        .wrap  (sym_req),
        .zero  (up_zero)
    );

    assign fir_en      = en_q;
    assign cordic_en   = en_q;
    assign busy        = en_q;
    assign tx_valid    = tx_valid_q;
    assign state_o     = state_q;
    assign err_timeout = tmo_q;
    assign err_desync  = desync_q;
endmodule
